// File: rtl/onehot_count_monitor.sv
// Monitor for a falling-edge 5-state one-hot up/down counter: decodes value and
// 7-segment digit, reports step/wrap events, counts wraps and latches faults.
module onehot_count_monitor #(
    parameter int WRAP_W         = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        q_in,
    input  logic              max_in,
    input  logic              clear_err,
    output logic [2:0]        val,
    output logic [6:0]        seg,
    output logic              step,
    output logic              dir_up,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wraps,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // XOR mask that turns an active-high pattern into the board polarity; also the blank code.
    localparam logic [6:0]        SEG_MASK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1'b1);

    function automatic logic sample_legal(input logic [5:0] s);
        logic [4:0] q;
        q = s[4:0];
        return (q != 5'd0) && ((q & (q - 5'd1)) == 5'd0) && (s[5] == s[4]);
    endfunction

    function automatic logic [2:0] to_bin(input logic [4:0] q);
        logic [2:0] b;
        case (q)
            5'b00001: b = 3'd0;
            5'b00010: b = 3'd1;
            5'b00100: b = 3'd2;
            5'b01000: b = 3'd3;
            5'b10000: b = 3'd4;
            default:  b = 3'd0;
        endcase
        return b;
    endfunction

    function automatic logic [6:0] to_seg(input logic [2:0] v);
        logic [6:0] p;
        case (v)
            3'd0:    p = 7'h3F;
            3'd1:    p = 7'h06;
            3'd2:    p = 7'h5B;
            3'd3:    p = 7'h4F;
            3'd4:    p = 7'h66;
            default: p = 7'h00;
        endcase
        return p ^ SEG_MASK;
    endfunction

    state_t            state_q, state_d;
    logic [5:0]        cur_q, cur_d;
    logic              cur_vld_q, cur_vld_d;
    logic [4:0]        prev_q, prev_d;
    logic [2:0]        val_q, val_d;
    logic [6:0]        seg_q, seg_d;
    logic              step_q, step_d;
    logic              dir_up_q, dir_up_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;
    logic              err_q, err_d;

    logic              cur_legal_s;
    logic [2:0]        cur_bin_s;
    logic [6:0]        cur_seg_s;
    logic [4:0]        rotl_s;
    logic [4:0]        rotr_s;

    assign cur_legal_s = sample_legal(cur_q);
    assign cur_bin_s   = to_bin(cur_q[4:0]);
    assign cur_seg_s   = to_seg(cur_bin_s);
    assign rotl_s      = {prev_q[3:0], prev_q[4]};
    assign rotr_s      = {prev_q[0], prev_q[4:1]};

    // Next-state and next-output logic; fault detection outranks step/wrap classification.
    always_comb begin
        state_d      = state_q;
        cur_d        = {max_in, q_in};
        cur_vld_d    = 1'b1;
        prev_d       = cur_q[4:0];
        val_d        = val_q;
        seg_d        = seg_q;
        step_d       = 1'b0;
        dir_up_d     = dir_up_q;
        wrap_pulse_d = 1'b0;
        wraps_d      = wraps_q;
        err_d        = err_q;

        case (state_q)
            ST_INIT: begin
                // cur still holds the reset filler until the first real sample lands
                if (!cur_vld_q) begin
                    state_d = ST_INIT;
                end else if (cur_legal_s) begin
                    val_d   = cur_bin_s;
                    seg_d   = cur_seg_s;
                    state_d = ST_TRACK;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_FAULT;
                end
            end
            ST_TRACK: begin
                if (!cur_legal_s) begin
                    err_d   = 1'b1;
                    state_d = ST_FAULT;
                end else if (cur_q[4:0] == prev_q) begin
                    val_d = cur_bin_s;
                    seg_d = cur_seg_s;
                end else if (cur_q[4:0] == rotl_s) begin
                    val_d    = cur_bin_s;
                    seg_d    = cur_seg_s;
                    step_d   = 1'b1;
                    dir_up_d = 1'b1;
                    if (prev_q[4]) begin
                        wrap_pulse_d = 1'b1;
                        wraps_d      = wraps_q + WRAP_ONE;
                    end else begin
                        wrap_pulse_d = 1'b0;
                    end
                end else if (cur_q[4:0] == rotr_s) begin
                    val_d    = cur_bin_s;
                    seg_d    = cur_seg_s;
                    step_d   = 1'b1;
                    dir_up_d = 1'b0;
                    if (prev_q[0]) begin
                        wrap_pulse_d = 1'b1;
                        wraps_d      = wraps_q - WRAP_ONE;
                    end else begin
                        wrap_pulse_d = 1'b0;
                    end
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (clear_err && cur_legal_s) begin
                    err_d   = 1'b0;
                    val_d   = cur_bin_s;
                    seg_d   = cur_seg_s;
                    state_d = ST_INIT;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Pipeline, FSM and output registers; reset discards all sample history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            cur_q        <= 6'b000001;
            cur_vld_q    <= 1'b0;
            prev_q       <= 5'b00001;
            val_q        <= 3'd0;
            seg_q        <= SEG_MASK;
            step_q       <= 1'b0;
            dir_up_q     <= 1'b1;
            wrap_pulse_q <= 1'b0;
            wraps_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            cur_vld_q    <= cur_vld_d;
            prev_q       <= prev_d;
            val_q        <= val_d;
            seg_q        <= seg_d;
            step_q       <= step_d;
            dir_up_q     <= dir_up_d;
            wrap_pulse_q <= wrap_pulse_d;
            wraps_q      <= wraps_d;
            err_q        <= err_d;
        end
    end

    assign val        = val_q;
    assign seg        = seg_q;
    assign step       = step_q;
    assign dir_up     = dir_up_q;
    assign wrap_pulse = wrap_pulse_q;
    assign wraps      = wraps_q;
    assign err        = err_q;

endmodule

// File: doc/onehot_count_monitor.md
Name: onehot_count_monitor

Overview:
- Downstream consumer of the 5-state one-hot up/down counter, which updates on the falling clock edge.
- Samples the counter's one-hot state and its max flag on the rising edge, half a cycle after each update.
- Decodes the state to binary and a 7-segment digit, and detects direction and step events.
- Accumulates a signed wrap count (higher-order digit) and flags illegal codes or illegal jumps with a sticky error.

Parameters:
- WRAP_W, 4, width of the wrap counter, modulo 2^WRAP_W.
- SEG_ACTIVE_LOW, 1, 1 = seg outputs active-low (lab board); 0 = active-high.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- q_in  input  5  one-hot counter state; bit k set = value k.
- max_in  input  1  counter max flag; must equal q_in[4].
- clear_err  input  1  synchronous request to leave FAULT.
- val  output  3  binary value 0..4 of the last legal sample.
- seg  output  7  gfedcba digit pattern of val.
- step  output  1  one-cycle pulse: value changed by a legal step.
- dir_up  output  1  direction of the last legal step (1 = up).
- wrap_pulse  output  1  one-cycle pulse on any wrap (up or down).
- wraps  output  WRAP_W  wrap count; +1 per up-wrap, -1 per down-wrap, modulo 2^WRAP_W.
- err  output  1  sticky fault flag.

Behaviour:

Pipeline:
- Edge n: cur <= {max_in, q_in}.
- Edge n+1: prev <= cur; all outputs registered from the cur vs prev comparison.
- Latency from q_in to outputs: 2 rising edges.

Reset (async, immediate):
- val=0, seg=blank (all segments off: 7'h7F if SEG_ACTIVE_LOW, else 7'h00).
- step=0, wrap_pulse=0, dir_up=1, wraps=0, err=0.
- cur=prev=5'b00001, state=INIT.
- Reset mid-operation discards all history; the first sample after release is treated as INIT.

Legality of cur:
- Exactly one bit of q_in set, and max_in == q_in[4].
- Otherwise illegal.

Transition classes (TRACK only), with rotl meaning bit i moves to i+1 and bit 4 moves to 0:
- cur == prev: hold; step=0.
- cur == rotl(prev): up step; step=1, dir_up=1. If prev=10000 and cur=00001: up-wrap, wrap_pulse=1, wraps+1.
- cur == rotr(prev): down step; step=1, dir_up=0. If prev=00001 and cur=10000: down-wrap, wrap_pulse=1, wraps-1.
- Any other legal code: illegal jump -> FAULT.

FSM:
- INIT:
  - Legal cur: load val/seg, step=0, no wrap, go to TRACK.
  - Illegal cur: go to FAULT.
- TRACK:
  - Classify as above; val/seg follow cur on hold or step.
  - Illegal code or illegal jump: go to FAULT.
- FAULT:
  - err=1; val, seg, wraps, dir_up frozen at the last legal values; step=0, wrap_pulse=0.
  - clear_err=1 with cur legal on the same edge: err=0, go to INIT (no step reported; wraps kept).
  - clear_err=1 with cur illegal: remain in FAULT.

Simultaneous events:
- The fault check has priority over step/wrap classification; no wrap is counted on the faulting edge.
- clear_err is ignored outside FAULT.

Wraps arithmetic:
- Unsigned modulo 2^WRAP_W.
- 0 minus 1 yields all-ones; all-ones plus 1 yields 0.

Segment patterns (active-high gfedcba), inverted when SEG_ACTIVE_LOW=1:
- 0 = 3F
- 1 = 06
- 2 = 5B
- 3 = 4F
- 4 = 66

Test Plan:
1. Reset, hold q_in=00001/max=0 for 3 cycles -> after 2 edges: val=0, seg=7'h40 (active-low), step=0, err=0, wraps=0.
2. Up sequence 00001, 00010, 00100, 01000, 10000 (max=1), 00001, one value per cycle -> step pulses each cycle, dir_up=1, val 0,1,2,3,4,0, single wrap_pulse on 4->0, wraps=1.
3. From val=0, down sequence 00001 -> 10000 -> 01000 -> wraps decrements 0 -> 4'hF, dir_up=0, val 4 then 3.
4. From val=1 (00010), apply 01000 (illegal jump) -> err=1, val stays 1, step=0. Then apply 00011 with clear_err=1 -> still FAULT. Then apply 00100 with clear_err=1 -> err=0, state INIT, val=2, no step, wraps unchanged.
5. q_in=10000 with max_in=0 -> FAULT (max mismatch). Assert reset mid-FAULT -> all outputs return to reset values immediately, without a clock edge.
6. Hold 00001 for 5 cycles with no change -> step=0 and wrap_pulse=0 throughout; val=0 held.
